// File: rtl/priority_bcd_encoder.sv
// -----------------------------------------------------------------------------
// priority_bcd_encoder
//
// Registered priority encoder for the switch bank that drives the seven-segment
// displays. The switch bus and mode bit are brought into the clock domain with a
// two-flop synchroniser. A registered encoder finds the highest set switch
// (MODE_I = 0) or the lowest set switch (MODE_I = 1). When that result differs
// from the displayed one, a sequential double-dabble FSM converts the index to
// NUM_DIGITS BCD digits. The digits are then presented with a one-cycle strobe.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - blank (4'hF) every digit above the most significant
//                           nonzero digit. Digit 0 is never blanked.
//
// Ports:
//   CLOCK_50_I  in   1               system clock, rising edge
//   resetn      in   1               synchronous active-low reset
//   SWITCH_I    in   NUM_SWITCHES    asynchronous switch inputs
//   MODE_I      in   1               0 = MSB priority, 1 = LSB priority
//   HOLD_I      in   1               1 = do not start a new conversion
//   DIGITS_O    out  4*NUM_DIGITS    BCD digits, digit 0 in [3:0], 4'hF = blank
//   INDEX_O     out  INDEX_W         displayed binary index
//   ANY_O       out  1               displayed result had a switch set
//   BUSY_O      out  1               FSM in CONVERT or DONE
//   UPDATE_O    out  1               one-cycle pulse when outputs change
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module priority_bcd_encoder #(
    parameter int NUM_SWITCHES = 18,
    parameter int NUM_DIGITS   = 2,
    parameter int INDEX_W      = $clog2(NUM_SWITCHES)
) (
    input  logic                    CLOCK_50_I,
    input  logic                    resetn,
    input  logic [NUM_SWITCHES-1:0] SWITCH_I,
    input  logic                    MODE_I,
    input  logic                    HOLD_I,
    output logic [4*NUM_DIGITS-1:0] DIGITS_O,
    output logic [INDEX_W-1:0]      INDEX_O,
    output logic                    ANY_O,
    output logic                    BUSY_O,
    output logic                    UPDATE_O
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + INDEX_W;
    localparam int CNT_W = $clog2(INDEX_W + 1);

    if (NUM_SWITCHES < 2 || NUM_SWITCHES > 64) begin : g_bad_switches
        $error("priority_bcd_encoder: NUM_SWITCHES must be in 2..64");
    end
    if (10 ** NUM_DIGITS < NUM_SWITCHES) begin : g_bad_digits
        $error("priority_bcd_encoder: NUM_DIGITS too small for NUM_SWITCHES");
    end

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t                  state;
    logic [NUM_SWITCHES-1:0] sw_meta, sw_sync;
    logic                    mode_meta, mode_sync;
    logic                    enc_any, enc_any_d;
    logic [INDEX_W-1:0]      enc_idx, enc_idx_d;
    logic                    lat_any;
    logic [INDEX_W-1:0]      lat_idx;
    logic [SR_W-1:0]         sr, sr_adj, sr_next;
    logic [CNT_W-1:0]        shift_cnt;
    logic [BCD_W-1:0]        bcd, digits_fmt;

    // Priority search: the last match in loop order wins, so the loop
    // direction selects highest-set (ascending) or lowest-set (descending).
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        enc_any_d = |sw_sync;
        enc_idx_d = '0;
        if (mode_sync) begin
            for (int i = NUM_SWITCHES - 1; i >= 0; i--)
                if (sw_sync[i]) enc_idx_d = INDEX_W'(i);
        end else begin
            for (int i = 0; i < NUM_SWITCHES; i++)
                if (sw_sync[i]) enc_idx_d = INDEX_W'(i);
        end
    end

    // One double-dabble step: correct each BCD nibble, then shift the whole
    // register left by one. The BCD field sits above the binary field.
    // NOTE: combinational logic uses blocking '=' so later lines see earlier results.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (sr_adj[INDEX_W + 4*d +: 4] >= 4'd5)
                sr_adj[INDEX_W + 4*d +: 4] = sr_adj[INDEX_W + 4*d +: 4] + 4'd3;
        sr_next = sr_adj << 1;
    end

    assign bcd = sr[SR_W-1 -: BCD_W];

    // Display formatting. A result with no switch set shows all blanks.
    always_comb begin
        digits_fmt = bcd;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic leading;
            leading = 1'b1;
            for (int d = NUM_DIGITS - 1; d > 0; d--) begin
                if (leading && bcd[4*d +: 4] == 4'd0)
                    digits_fmt[4*d +: 4] = 4'hF;
                else
                    leading = 1'b0;
            end
        end
`endif
        if (!lat_any)
            digits_fmt = '1;
    end

    // NOTE: every register, including the shift register, is reset so a reset
    // mid-conversion leaves no stale state behind.
    always_ff @(posedge CLOCK_50_I) begin
        if (!resetn) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            mode_meta <= 1'b0;
            mode_sync <= 1'b0;
            enc_any   <= 1'b0;
            enc_idx   <= '0;
            lat_any   <= 1'b0;
            lat_idx   <= '0;
            sr        <= '0;
            shift_cnt <= '0;
            state     <= IDLE;
            DIGITS_O  <= '1;
            INDEX_O   <= '0;
            ANY_O     <= 1'b0;
            BUSY_O    <= 1'b0;
            UPDATE_O  <= 1'b0;
        end else begin
            sw_meta   <= SWITCH_I;
            sw_sync   <= sw_meta;
            mode_meta <= MODE_I;
            mode_sync <= mode_meta;
            enc_any   <= enc_any_d;
            enc_idx   <= enc_idx_d;
            UPDATE_O  <= 1'b0;

            case (state)
                IDLE: begin
                    // Inputs that moved during a conversion are caught here,
                    // so the display always converges to the current switches.
                    if ({enc_any, enc_idx} != {ANY_O, INDEX_O} && !HOLD_I) begin
                        lat_any   <= enc_any;
                        lat_idx   <= enc_idx;
                        sr        <= {{BCD_W{1'b0}}, enc_idx};
                        shift_cnt <= '0;
                        BUSY_O    <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr        <= sr_next;
                    shift_cnt <= shift_cnt + 1'b1;
                    if (shift_cnt == CNT_W'(INDEX_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    INDEX_O  <= lat_idx;
                    ANY_O    <= lat_any;
                    DIGITS_O <= digits_fmt;
                    UPDATE_O <= 1'b1;
                    BUSY_O   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
